axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter RD_BEATS, default 4, meaning beats per read burst (1..16).
REQ-002 SHALL have parameter WR_BEATS, default 1, meaning beats per write burst (1..16).
REQ-003 SHALL have parameter MID, default 0, meaning value driven on AWID and ARID.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port master  AXI_master_p.master  -  AXI4 master port, 32-bit data and address.
REQ-007 SHALL have port req  input  1  CPU transaction request.
REQ-008 SHALL have port write  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-009 SHALL have port w_type  input  3  CACHE_BYTE/CACHE_HWORD/word encoding; sampled at acceptance.
REQ-010 SHALL have port addr  input  32  byte address; sampled at acceptance.
REQ-011 SHALL have port data_in  input  32  current write beat data.
REQ-012 SHALL have port wbeat_ack  output  1  pulse, current write beat consumed.
REQ-013 SHALL have port data_out  output  32  current read beat data.
REQ-014 SHALL have port rbeat_valid  output  1  data_out valid this cycle.
REQ-015 SHALL have port rbeat_idx  output  4  index of current read beat.
REQ-016 SHALL have port done  output  1  pulse, transaction complete.
REQ-017 SHALL have port err  output  1  response error, valid with done.
REQ-018 SHALL have port stall  output  1  CPU must hold.

Function
REQ-019 SHALL implement states IDLE, RD, WR, WRESP.
REQ-020 IDLE SHALL accept req=1, latch addr/write/w_type, and go to WR if write=1, else to RD, with AXI valids first high in the next cycle.
REQ-021 RD SHALL drive ARVALID=1 until ARREADY; ARADDR=addr aligned down to 4*RD_BEATS bytes; ARLEN=RD_BEATS-1; ARSIZE=2; ARBURST=INCR.
REQ-022 RD SHALL drive RREADY=1 for the whole state; each R handshake pulses rbeat_valid, drives data_out=RDATA, and increments the beat counter that drives rbeat_idx.
REQ-023 RD SHALL exit to IDLE on the R handshake with RLAST=1.
REQ-024 WR SHALL drive AWVALID and WVALID concurrently from state entry; AWADDR=addr when WR_BEATS=1, else addr aligned to 4*WR_BEATS; AWLEN=WR_BEATS-1; AWSIZE=2; AWBURST=INCR.
REQ-025 AWVALID SHALL drop after AW handshake, tracked by a done flag; WVALID SHALL remain high until the last W handshake.
REQ-026 WDATA SHALL equal data_in; wbeat_ack SHALL equal WVALID&WREADY; WLAST SHALL be 1 when write counter = WR_BEATS-1.
REQ-027 WSTRB SHALL decode w_type (byte/hword/word per AXI_STRB_* of latched addr) when WR_BEATS=1, else 4'hF.
REQ-028 WR SHALL go to WRESP once both AW and last W are handshaken, including when they complete in the same cycle.
REQ-029 WRESP SHALL drive BREADY=1 and return to IDLE on BVALID.
REQ-030 done SHALL pulse in the completion cycle (RLAST or B handshake); err SHALL be 1 then if any RRESP/BRESP != OKAY in the transaction, or if RLAST arrives at counter != RD_BEATS-1.
REQ-031 stall SHALL equal req in IDLE, 1 in RD/WR/WRESP, and 0 in the completion cycle.
REQ-032 A new req SHALL be accepted no earlier than the cycle after done.
REQ-033 Once asserted, any VALID SHALL remain high with stable payload until its handshake.
REQ-034 An R or B beat arriving in an unrelated state SHALL be ignored, since the READY signals are low.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL go to IDLE, with all VALID/READY, counters, flags, wbeat_ack, rbeat_valid, done and err = 0 at that edge, including mid-burst.
REQ-036 data_out SHALL follow RDATA combinationally and has no reset value.

Verification
REQ-037 Read test: RD_BEATS=4, addr=0x1234, ARREADY=1 at once, R beats 0xA..0xD with RLAST on the 4th. Required: ARADDR=0x1230, ARLEN=3, rbeat_idx 0..3, done and err=0 on the 4th beat.
REQ-038 Write test: WR_BEATS=1, w_type=byte, addr=0x3, AWREADY delayed 3 cycles, WREADY=1. Required: W is accepted before AW, WSTRB=4'b1000, BREADY follows, done on BVALID.
REQ-039 Burst write test: WR_BEATS=4, AW and W handshakes land in the same cycle on the last beat. Required: 4 wbeat_ack pulses, WLAST only on beat 3, WRESP entered next cycle.
REQ-040 Error test: read with RRESP=SLVERR on beat 2. Required: err=1 with done; a subsequent clean read gives err=0.
REQ-041 Reset test: rst asserted during read beat 2. Required: RREADY=0, stall=0 with req=0, and state IDLE next cycle; the following read completes normally.
REQ-042 Back-to-back test: req held high across done. Required: the second AR is issued exactly 2 cycles after done.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle (32-bit address and data, 4-bit IDs) as seen from the master side.
interface AXI_master_p;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Turns single CPU read/write requests into fixed-length AXI4 INCR bursts.
module axi_burst_master #(
    parameter int         RD_BEATS = 4,
    parameter int         WR_BEATS = 1,
    parameter logic [3:0] MID      = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    AXI_master_p.master master,
    input  logic        req,
    input  logic        write,
    input  logic [2:0]  w_type,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        wbeat_ack,
    output logic [31:0] data_out,
    output logic        rbeat_valid,
    output logic [3:0]  rbeat_idx,
    output logic        done,
    output logic        err,
    output logic        stall
);
    localparam logic [2:0]  CACHE_BYTE  = 3'd0;
    localparam logic [2:0]  CACHE_HWORD = 3'd1;
    localparam logic [31:0] RD_SPAN     = 32'(4 * RD_BEATS);
    localparam logic [31:0] WR_SPAN     = 32'(4 * WR_BEATS);
    localparam logic [3:0]  RD_LAST     = 4'(RD_BEATS - 1);
    localparam logic [3:0]  WR_LAST     = 4'(WR_BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t      state;
    logic [31:0] ar_addr_q, aw_addr_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  rd_cnt, wr_cnt;
    logic        ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic        aw_done, w_done, err_acc;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, w_last, r_last_hs, aw_ok, w_ok;

    function automatic logic [3:0] strb_decode(input logic [2:0] wt, input logic [1:0] a);
        case (wt)
            CACHE_BYTE:  return 4'b0001 << a;
            CACHE_HWORD: return a[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    assign ar_hs     = ar_valid_q & master.arready;
    assign r_hs      = r_ready_q & master.rvalid;
    assign aw_hs     = aw_valid_q & master.awready;
    assign w_hs      = w_valid_q & master.wready;
    assign b_hs      = b_ready_q & master.bvalid;
    assign w_last    = w_valid_q & (wr_cnt == WR_LAST);
    assign r_last_hs = r_hs & master.rlast;
    // Either channel may finish first; the flags remember which one already did.
    assign aw_ok     = aw_done | aw_hs;
    assign w_ok      = w_done | (w_hs & w_last);

    // READY is only ever high in its own state, so these cannot fire elsewhere.
    assign done        = r_last_hs | b_hs;
    assign err         = done & (err_acc
                                 | (r_hs & (master.rresp != 2'b00))
                                 | (b_hs & (master.bresp != 2'b00))
                                 | (r_last_hs & (rd_cnt != RD_LAST)));
    assign stall       = (state == IDLE) ? req : ~done;
    assign wbeat_ack   = w_hs;
    assign rbeat_valid = r_hs;
    assign rbeat_idx   = rd_cnt;
    assign data_out    = master.rdata;

    assign master.arid    = MID;
    assign master.araddr  = ar_addr_q;
    assign master.arlen   = 8'(RD_BEATS - 1);
    assign master.arsize  = 3'd2;
    assign master.arburst = 2'b01;
    assign master.arvalid = ar_valid_q;
    assign master.rready  = r_ready_q;
    assign master.awid    = MID;
    assign master.awaddr  = aw_addr_q;
    assign master.awlen   = 8'(WR_BEATS - 1);
    assign master.awsize  = 3'd2;
    assign master.awburst = 2'b01;
    assign master.awvalid = aw_valid_q;
    assign master.wdata   = data_in;
    assign master.wstrb   = wstrb_q;
    assign master.wlast   = w_last;
    assign master.wvalid  = w_valid_q;
    assign master.bready  = b_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            err_acc    <= 1'b0;
            rd_cnt     <= 4'd0;
            wr_cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    err_acc   <= 1'b0;
                    rd_cnt    <= 4'd0;
                    wr_cnt    <= 4'd0;
                    ar_addr_q <= addr - addr % RD_SPAN;
                    aw_addr_q <= (WR_BEATS == 1) ? addr : addr - addr % WR_SPAN;
                    wstrb_q   <= (WR_BEATS == 1) ? strb_decode(w_type, addr[1:0]) : 4'hF;
                    if (write) begin
                        state      <= WR;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                    end else begin
                        state      <= RD;
                        ar_valid_q <= 1'b1;
                        r_ready_q  <= 1'b1;
                    end
                end
                RD: begin
                    if (ar_hs)
                        ar_valid_q <= 1'b0;
                    if (r_hs) begin
                        rd_cnt <= rd_cnt + 4'd1;
                        if (master.rresp != 2'b00)
                            err_acc <= 1'b1;
                        if (master.rlast) begin
                            state      <= IDLE;
                            r_ready_q  <= 1'b0;
                            ar_valid_q <= 1'b0;
                            rd_cnt     <= 4'd0;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        if (w_last) begin
                            w_valid_q <= 1'b0;
                            w_done    <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 4'd1;
                        end
                    end
                    if (aw_ok && w_ok) begin
                        state      <= WRESP;
                        b_ready_q  <= 1'b1;
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b0;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        wr_cnt     <= 4'd0;
                    end
                end
                WRESP: if (b_hs) begin
                    state     <= IDLE;
                    b_ready_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: single-beat writer (dut_a) and 4-beat burst writer (dut_b) against a slave model.
module tb_axi_burst_master;
    localparam int RDB = 4;

    logic        clk = 1'b0;
    logic        rst, req, write;
    logic [2:0]  w_type;
    logic [31:0] addr, data_in;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    bit          sel = 1'b0;
    int          compared = 0, mismatched = 0, ncyc = 0;

    logic        wbeat_ack_a, rbeat_valid_a, done_a, err_a, stall_a;
    logic        wbeat_ack_b, rbeat_valid_b, done_b, err_b, stall_b;
    logic [31:0] data_out_a, data_out_b;
    logic [3:0]  rbeat_idx_a, rbeat_idx_b;

    AXI_master_p axa();
    AXI_master_p axb();

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    assign axa.arready = arready; assign axb.arready = arready;
    assign axa.rvalid  = rvalid;  assign axb.rvalid  = rvalid;
    assign axa.rlast   = rlast;   assign axb.rlast   = rlast;
    assign axa.rdata   = rdata;   assign axb.rdata   = rdata;
    assign axa.rresp   = rresp;   assign axb.rresp   = rresp;
    assign axa.awready = awready; assign axb.awready = awready;
    assign axa.wready  = wready;  assign axb.wready  = wready;
    assign axa.bvalid  = bvalid;  assign axb.bvalid  = bvalid;
    assign axa.bresp   = bresp;   assign axb.bresp   = bresp;

    wire req_a = req & ~sel;
    wire req_b = req & sel;

    axi_burst_master #(.RD_BEATS(RDB), .WR_BEATS(1), .MID(4'd5)) dut_a (
        .clk(clk), .rst(rst), .master(axa), .req(req_a), .write(write), .w_type(w_type),
        .addr(addr), .data_in(data_in), .wbeat_ack(wbeat_ack_a), .data_out(data_out_a),
        .rbeat_valid(rbeat_valid_a), .rbeat_idx(rbeat_idx_a), .done(done_a), .err(err_a),
        .stall(stall_a));

    axi_burst_master #(.RD_BEATS(RDB), .WR_BEATS(4), .MID(4'd9)) dut_b (
        .clk(clk), .rst(rst), .master(axb), .req(req_b), .write(write), .w_type(w_type),
        .addr(addr), .data_in(data_in), .wbeat_ack(wbeat_ack_b), .data_out(data_out_b),
        .rbeat_valid(rbeat_valid_b), .rbeat_idx(rbeat_idx_b), .done(done_b), .err(err_b),
        .stall(stall_b));

    // Observed signals of whichever instance is currently selected.
    wire        arvalid_o = sel ? axb.arvalid : axa.arvalid;
    wire        rready_o  = sel ? axb.rready  : axa.rready;
    wire        awvalid_o = sel ? axb.awvalid : axa.awvalid;
    wire        wvalid_o  = sel ? axb.wvalid  : axa.wvalid;
    wire        bready_o  = sel ? axb.bready  : axa.bready;
    wire        wack_o    = sel ? wbeat_ack_b   : wbeat_ack_a;
    wire        rbv_o     = sel ? rbeat_valid_b : rbeat_valid_a;
    wire        done_o    = sel ? done_b  : done_a;
    wire        err_o     = sel ? err_b   : err_a;
    wire        stall_o   = sel ? stall_b : stall_a;
    wire [31:0] dout_o    = sel ? data_out_b  : data_out_a;
    wire [3:0]  ridx_o    = sel ? rbeat_idx_b : rbeat_idx_a;
    wire [48:0] ar_pl_o   = sel ? {axb.araddr, axb.arlen, axb.arsize, axb.arburst, axb.arid}
                                : {axa.araddr, axa.arlen, axa.arsize, axa.arburst, axa.arid};
    wire [48:0] aw_pl_o   = sel ? {axb.awaddr, axb.awlen, axb.awsize, axb.awburst, axb.awid}
                                : {axa.awaddr, axa.awlen, axa.awsize, axa.awburst, axa.awid};
    wire [36:0] w_pl_o    = sel ? {axb.wdata, axb.wstrb, axb.wlast} : {axa.wdata, axa.wstrb, axa.wlast};
    wire [13:0] ctl_o     = {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, wack_o, rbv_o,
                             done_o, err_o, stall_o, ridx_o};

    task automatic quiet_slave();
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    // One read burst on the selected DUT; the slave returns beats 0..last_beat, RRESP bad on bad_beat.
    task automatic do_read(input logic [31:0] a, input int ar_dly, input int bad_beat,
                           input int last_beat, input bit pre, input bit keep,
                           input logic [31:0] next_a, output int done_cyc, output int ar_cyc0);
        logic [31:0] exp_ar;
        logic [3:0]  exp_id;
        bit          exp_err, ar_t, fin, ldone;
        int          beat, cyc;
        exp_ar  = a - a % (4 * RDB);
        exp_id  = sel ? 4'd9 : 4'd5;
        exp_err = (bad_beat >= 0 && bad_beat <= last_beat) || (last_beat != RDB - 1);
        ar_t = 0; fin = 0; beat = 0; cyc = 0; done_cyc = -1;
        if (!pre) begin
            @(negedge clk); req = 1; write = 0; addr = a; w_type = 3'($urandom);
        end
        @(negedge clk);
        ar_cyc0 = ncyc;
        if (!keep) req = 0;
        addr = keep ? next_a : $urandom;
        while (!fin && cyc < 300) begin
            arready = ar_t ? 1'($urandom) : (cyc >= ar_dly);
            rvalid  = ar_t && ($urandom_range(0, 2) != 0);
            rdata   = $urandom;
            rresp   = (beat == bad_beat) ? 2'b10 : 2'b00;
            rlast   = (beat == last_beat);
            awready = 1'($urandom); wready = 1'($urandom); bvalid = 1'($urandom); bresp = 2'($urandom);
            #1;
            ldone = rvalid && rlast;
            compared++;
            if (arvalid_o !== !ar_t) begin
                mismatched++; $display("FAIL rd_arvalid: got %0b want %0b", arvalid_o, !ar_t);
            end
            if (!ar_t) begin
                compared++;
                if (ar_pl_o !== {exp_ar, 8'd3, 3'd2, 2'd1, exp_id}) begin
                    mismatched++; $display("FAIL rd_ar_payload: got %h want %h", ar_pl_o, {exp_ar, 8'd3, 3'd2, 2'd1, exp_id});
                end
            end
            compared++;
            if ({rready_o, awvalid_o, wvalid_o, bready_o, wack_o} !== 5'b10000) begin
                mismatched++; $display("FAIL rd_ready_set: got %b want 10000", {rready_o, awvalid_o, wvalid_o, bready_o, wack_o});
            end
            compared++;
            if ({rbv_o, done_o, stall_o} !== {rvalid, ldone, !ldone}) begin
                mismatched++; $display("FAIL rd_beat_ctl: got %b want %b", {rbv_o, done_o, stall_o}, {rvalid, ldone, !ldone});
            end
            if (rvalid) begin
                compared++;
                if ({dout_o, ridx_o} !== {rdata, 4'(beat)}) begin
                    mismatched++; $display("FAIL rd_beat_data: got %h/%0d want %h/%0d", dout_o, ridx_o, rdata, beat);
                end
            end
            if (ldone) begin
                compared++;
                if (err_o !== exp_err) begin
                    mismatched++; $display("FAIL rd_err: got %0b want %0b", err_o, exp_err);
                end
            end
            if (!ar_t && arready) ar_t = 1;
            if (rvalid) begin
                if (rlast) begin fin = 1; done_cyc = ncyc; end
                beat++;
            end
            @(negedge clk); cyc++;
        end
        quiet_slave();
        if (!fin) begin
            compared++; mismatched++; $display("FAIL rd_timeout: got no done want done");
        end
        #1;
        compared++;
        if ({rready_o, arvalid_o, done_o, stall_o} !== {3'b000, req}) begin
            mismatched++; $display("FAIL rd_after_done: got %b want %b", {rready_o, arvalid_o, done_o, stall_o}, {3'b000, req});
        end
    endtask

    // One write on the selected DUT (1 beat on dut_a, 4 beats on dut_b).
    task automatic do_write(input logic [31:0] a, input logic [2:0] wt, input int aw_dly,
                            input int w_gap, input bit bad, output int aw_cyc, output int wl_cyc,
                            output int acks);
        int          nb, wb, cyc;
        logic [31:0] exp_aw;
        logic [3:0]  exp_strb, exp_id;
        bit          aw_t, w_t, inresp, fin, exp_wl;
        nb = sel ? 4 : 1;
        exp_aw = (nb == 1) ? a : a - a % (4 * nb);
        exp_id = sel ? 4'd9 : 4'd5;
        if (nb != 1)         exp_strb = 4'hF;
        else if (wt == 3'd0) exp_strb = 4'(1 << (a % 4));
        else if (wt == 3'd1) exp_strb = (a % 4 >= 2) ? 4'b1100 : 4'b0011;
        else                 exp_strb = 4'hF;
        aw_t = 0; w_t = 0; inresp = 0; fin = 0; wb = 0; cyc = 0; acks = 0; aw_cyc = -1; wl_cyc = -1;
        @(negedge clk); req = 1; write = 1; addr = a; w_type = wt;
        @(negedge clk); req = 0; addr = $urandom; w_type = 3'($urandom);
        while (!fin && cyc < 300) begin
            awready = aw_t ? 1'($urandom) : (cyc >= aw_dly);
            wready  = (w_gap == 0) ? 1'b1 : ($urandom_range(0, w_gap) == 0);
            data_in = $urandom;
            rvalid = 1'($urandom); rlast = 1'($urandom); rresp = 2'($urandom); arready = 1'($urandom);
            bvalid  = inresp ? ($urandom_range(0, 1) == 0) : 1'($urandom);
            bresp   = inresp ? (bad ? 2'b10 : 2'b00) : 2'($urandom);
            #1;
            compared++;
            if (rbv_o !== 1'b0) begin
                mismatched++; $display("FAIL wr_stray_r: got %0b want 0", rbv_o);
            end
            if (!inresp) begin
                exp_wl = (wb == nb - 1);
                compared++;
                if ({awvalid_o, wvalid_o, wack_o, bready_o, done_o, stall_o} !== {!aw_t, !w_t, !w_t && wready, 3'b001}) begin
                    mismatched++; $display("FAIL wr_ctl: got %b want %b", {awvalid_o, wvalid_o, wack_o, bready_o, done_o, stall_o}, {!aw_t, !w_t, !w_t && wready, 3'b001});
                end
                if (!aw_t) begin
                    compared++;
                    if (aw_pl_o !== {exp_aw, 8'(nb - 1), 3'd2, 2'd1, exp_id}) begin
                        mismatched++; $display("FAIL wr_aw_payload: got %h want %h", aw_pl_o, {exp_aw, 8'(nb - 1), 3'd2, 2'd1, exp_id});
                    end
                end
                if (!w_t) begin
                    compared++;
                    if (w_pl_o !== {data_in, exp_strb, exp_wl}) begin
                        mismatched++; $display("FAIL wr_w_payload: got %h want %h", w_pl_o, {data_in, exp_strb, exp_wl});
                    end
                end
                if (!aw_t && awready) begin aw_t = 1; aw_cyc = cyc; end
                if (!w_t && wready) begin
                    acks++;
                    if (exp_wl) begin w_t = 1; wl_cyc = cyc; end else wb++;
                end
                if (aw_t && w_t) inresp = 1;
            end else begin
                compared++;
                if ({bready_o, awvalid_o, wvalid_o, wack_o, done_o, stall_o} !== {4'b1000, bvalid, !bvalid}) begin
                    mismatched++; $display("FAIL wresp_ctl: got %b want %b", {bready_o, awvalid_o, wvalid_o, wack_o, done_o, stall_o}, {4'b1000, bvalid, !bvalid});
                end
                if (bvalid) begin
                    fin = 1;
                    compared++;
                    if (err_o !== bad) begin
                        mismatched++; $display("FAIL wr_err: got %0b want %0b", err_o, bad);
                    end
                end
            end
            @(negedge clk); cyc++;
        end
        quiet_slave();
        if (!fin) begin
            compared++; mismatched++; $display("FAIL wr_timeout: got no done want done");
        end
        #1;
        compared++;
        if ({bready_o, awvalid_o, wvalid_o, done_o, stall_o} !== 5'b00000) begin
            mismatched++; $display("FAIL wr_after_done: got %b want 00000", {bready_o, awvalid_o, wvalid_o, done_o, stall_o});
        end
    endtask

    task automatic test_reset();
        rst = 1; req = 0; write = 0; w_type = 0; addr = 0; data_in = 0; quiet_slave();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            compared++;
            if (ctl_o !== 14'd0) begin
                mismatched++; $display("FAIL reset_state: got %b want 0", ctl_o);
            end
        end
        sel = 0; rst = 0;
        @(negedge clk); req = 1; #1;
        compared++;
        if (stall_o !== 1'b1) begin
            mismatched++; $display("FAIL idle_stall_req: got %0b want 1", stall_o);
        end
        req = 0;
    endtask

    task automatic test_read();
        int d0, d1;
        sel = 0;
        do_read(32'h1234, 0, -1, 3, 0, 0, 0, d0, d1);
        do_read(32'h8000_00FF, 2, -1, 3, 0, 0, 0, d0, d1);
    endtask

    task automatic test_write_byte();
        int awc, wlc, acks;
        sel = 0;
        do_write(32'h3, 3'd0, 3, 0, 0, awc, wlc, acks);
        compared++;
        if (!(wlc >= 0 && wlc < awc)) begin
            mismatched++; $display("FAIL w_before_aw: got w@%0d aw@%0d want w earlier", wlc, awc);
        end
        do_write(32'h6, 3'd1, 0, 0, 1, awc, wlc, acks);
    endtask

    task automatic test_burst_write();
        int awc, wlc, acks;
        sel = 1;
        do_write(32'h0000_1238, 3'd0, 3, 0, 0, awc, wlc, acks);
        compared++;
        if ({acks, awc} !== {32'd4, wlc} || wlc != 3) begin
            mismatched++; $display("FAIL burst_same_cycle: got acks=%0d aw@%0d wlast@%0d want 4,3,3", acks, awc, wlc);
        end
        sel = 0;
    endtask

    task automatic test_error();
        int d0, d1;
        sel = 0;
        do_read(32'h40, 0, 2, 3, 0, 0, 0, d0, d1);
        do_read(32'h44, 0, -1, 3, 0, 0, 0, d0, d1);
        do_read(32'h48, 1, -1, 1, 0, 0, 0, d0, d1);
    endtask

    task automatic test_reset_mid();
        int d0, d1;
        sel = 0;
        @(negedge clk); req = 1; write = 0; addr = 32'h100;
        @(negedge clk); req = 0; arready = 1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); arready = 0; rvalid = 1; rlast = 0; rdata = $urandom;
        end
        @(negedge clk); rvalid = 1; rst = 1;
        @(negedge clk); rst = 0; quiet_slave(); #1;
        compared++;
        if (ctl_o !== 14'd0) begin
            mismatched++; $display("FAIL reset_mid_burst: got %b want 0", ctl_o);
        end
        do_read(32'h204, 0, -1, 3, 0, 0, 0, d0, d1);
    endtask

    task automatic test_back_to_back();
        int dc, a0, dx, ac;
        sel = 0;
        do_read(32'h500, 0, -1, 3, 0, 1, 32'h610, dc, a0);
        do_read(32'h610, 0, -1, 3, 1, 0, 0, dx, ac);
        compared++;
        if (ac - dc !== 2) begin
            mismatched++; $display("FAIL back_to_back_gap: got %0d want 2", ac - dc);
        end
    endtask

    task automatic test_random();
        int d0, d1, lb, bb, awc, wlc, acks;
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom);
            if (!sel && $urandom_range(0, 1) == 0) begin
                lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 3;
                bb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
                do_read($urandom, $urandom_range(0, 4), bb, lb, 0, 0, 0, d0, d1);
            end else begin
                do_write($urandom, 3'($urandom_range(0, 3)), $urandom_range(0, 5),
                         $urandom_range(0, 2), ($urandom_range(0, 3) == 0), awc, wlc, acks);
                compared++;
                if (acks !== (sel ? 4 : 1)) begin
                    mismatched++; $display("FAIL rand_wbeat_acks: got %0d want %0d", acks, sel ? 4 : 1);
                end
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_byte();
        test_burst_write();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
